// File: rtl/timer_pin_periph_if.sv
// Register bus between the control unit and the timer peripheral.
// Latency: none; this is wiring only. The read data is registered inside the peripheral.
// Backpressure: none. Strobes are single-cycle and always accepted.
// Ports (via modports):
//   master (CU side): drives wr_en, rd_en, addr, wdata; receives rdata
//   slave (peripheral side): receives wr_en, rd_en, addr, wdata; drives rdata
interface timer_pin_periph_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic             rd_en;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output wr_en, output rd_en, output addr, output wdata, input rdata);
  modport slave  (input wr_en, input rd_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_pin_periph.sv
// Bus-mapped timer that prescales clk, counts up to a compare value and toggles a GPIO pin on each match.
// Latency: writes take effect on the strobe edge. Read data appears one cycle after rd_en.
// Backpressure: none. Every bus access is accepted in the cycle it is presented.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  asynchronous, active-low reset
//   bus    register bus (slave modport): wr_en, rd_en, addr, wdata, rdata
//   pin    timer-driven GPIO output
//   irq    match interrupt, flag & CTRL[2] (present only with TIMER_IRQ_EN)
// Register map: 0 CTRL {flag,0..,irq_mask,periodic,en}, 1 PRESC, 2 CMP, 3 COUNT (write bit0=1 clears flag)
// Optional feature macro: TIMER_IRQ_EN (adds the irq output)
module timer_pin_periph #(
  parameter int   WIDTH     = 8,
  parameter logic PIN_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_pin_periph_if.slave    bus,
  output logic                 pin
`ifdef TIMER_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       ctrl,    ctrl_nxt;
  logic [WIDTH-1:0] presc,   presc_nxt;
  logic [WIDTH-1:0] cmp,     cmp_nxt;
  logic [WIDTH-1:0] pre_cnt, pre_nxt;
  logic [WIDTH-1:0] count,   count_nxt;
  logic             flag,    flag_nxt;
  logic             pin_nxt;
  logic [WIDTH-1:0] rd_val;
  logic             tick;
  logic             match;

  // Next-state logic. The timer update is evaluated first and bus writes
  // override it, except that a match always sets the flag (set beats W1C).
  always_comb begin
    ctrl_nxt  = ctrl;
    presc_nxt = presc;
    cmp_nxt   = cmp;
    pre_nxt   = pre_cnt;
    count_nxt = count;
    flag_nxt  = flag;
    pin_nxt   = pin;
    tick      = ctrl[0] && (pre_cnt == presc);
    match     = tick && (count == cmp);

    if (ctrl[0]) begin
      if (tick) begin
        pre_nxt   = '0;
        count_nxt = match ? '0 : count + ONE;  // natural wrap past 2^WIDTH-1
      end else begin
        pre_nxt   = pre_cnt + ONE;
      end
    end

    if (match) begin
      pin_nxt = ~pin;
      if (!ctrl[1]) ctrl_nxt[0] = 1'b0;     // one-shot ends after its match
    end

    if (bus.wr_en) begin
      case (bus.addr)
        2'd0: begin
          // A CTRL write disabling en lands after the match above completed,
          // so that match still updates flag and pin on this edge.
          ctrl_nxt = bus.wdata[2:0];
          if (!ctrl[0] && bus.wdata[0]) begin
            pre_nxt   = '0;
            count_nxt = '0;
          end
        end
        2'd1:    presc_nxt = bus.wdata;
        2'd2:    cmp_nxt   = bus.wdata;
        default: if (bus.wdata[0]) flag_nxt = 1'b0;
      endcase
    end

    if (match) flag_nxt = 1'b1;
  end

  // Read mux sees pre-edge values, so a same-cycle write returns the old value.
  always_comb begin
    rd_val = '0;
    case (bus.addr)
      2'd0:    rd_val = {flag, {(WIDTH-4){1'b0}}, ctrl};
      2'd1:    rd_val = presc;
      2'd2:    rd_val = cmp;
      default: rd_val = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl      <= '0;
      presc     <= '0;
      cmp       <= '0;
      pre_cnt   <= '0;
      count     <= '0;
      flag      <= 1'b0;
      pin       <= PIN_RESET;
      bus.rdata <= '0;
    end else begin
      ctrl    <= ctrl_nxt;
      presc   <= presc_nxt;
      cmp     <= cmp_nxt;
      pre_cnt <= pre_nxt;
      count   <= count_nxt;
      flag    <= flag_nxt;
      pin     <= pin_nxt;
      if (bus.rd_en) bus.rdata <= rd_val;
    end
  end

`ifdef TIMER_IRQ_EN
  // Built from next-state values so irq rises on the same edge as flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= flag_nxt & ctrl_nxt[2];
  end
`endif

endmodule

// File: tb/tb_timer_pin_periph.sv
module tb_timer_pin_periph;
  localparam int W = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       pin;
  logic       exp_pin;
  logic [7:0] d;
  int         checks   = 0;
  int         failures = 0;

  timer_pin_periph_if #(.WIDTH(W)) bus();
`ifdef TIMER_IRQ_EN
  logic irq;
`endif

  timer_pin_periph #(.WIDTH(W), .PIN_RESET(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .pin   (pin)
`ifdef TIMER_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    v = bus.rdata;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 8'h00;

    // 1: reset state
    #12 reset = 1'b1;
    @(negedge clk);
    chk("rst_pin", 8'(pin), 8'h00);
    chk("rst_rdata", bus.rdata, 8'h00);
    rd(2'd0, d); chk("rst_ctrl", d, 8'h00);
    rd(2'd1, d); chk("rst_presc", d, 8'h00);
    rd(2'd2, d); chk("rst_cmp", d, 8'h00);
    rd(2'd3, d); chk("rst_count", d, 8'h00);

    // 2: periodic, PRESC=0 CMP=4, toggle every 5 clocks; rdata tracks COUNT
    wr(2'd1, 8'd0);
    wr(2'd2, 8'd4);
    wr(2'd0, 8'h03);
    bus.rd_en = 1'b1;
    bus.addr  = 2'd3;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("per_pin", 8'(pin), 8'((k / 5) % 2));
      chk("per_count", bus.rdata, 8'((k - 1) % 5));
    end
    bus.rd_en = 1'b0;
    exp_pin = 1'b1;
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h01);

    // 3: one-shot, PRESC=3 CMP=2, single toggle 12 clocks after enable
    wr(2'd1, 8'd3);
    wr(2'd2, 8'd2);
    wr(2'd0, 8'h01);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("os_pin", 8'(pin), 8'(exp_pin ^ (k >= 12)));
    end
    exp_pin = ~exp_pin;
    rd(2'd0, d); chk("os_ctrl", d, 8'h80);
    rd(2'd3, d); chk("os_count", d, 8'h00);

    // 4: CMP lowered below a running COUNT=9 -> wraps, toggles 250 ticks later
    wr(2'd3, 8'h01);
    wr(2'd1, 8'd0);
    wr(2'd2, 8'd200);
    wr(2'd0, 8'h07);
    repeat (9) @(negedge clk);
    wr(2'd2, 8'd3);
    for (int j = 1; j <= 252; j++) begin
      @(negedge clk);
      chk("wrap_pin", 8'(pin), 8'(exp_pin ^ (j >= 250)));
    end
    exp_pin = ~exp_pin;

    // 5: W1C in the match cycle keeps flag; a later W1C clears it
    @(negedge clk);
    wr(2'd3, 8'h01);
    exp_pin = ~exp_pin;
    chk("w1c_pin", 8'(pin), 8'(exp_pin));
`ifdef TIMER_IRQ_EN
    chk("irq_set", 8'(irq), 8'h01);
`endif
    rd(2'd0, d); chk("w1c_keep", d, 8'h87);
    wr(2'd3, 8'h01);
`ifdef TIMER_IRQ_EN
    chk("irq_clr", 8'(irq), 8'h00);
`endif
    rd(2'd0, d); chk("w1c_clear", d, 8'h07);
    // CTRL en=0 written on a match edge: match completes, then stop
    wr(2'd0, 8'h00);
    exp_pin = ~exp_pin;
    chk("stop_pin", 8'(pin), 8'(exp_pin));
    rd(2'd3, d); chk("stop_count", d, 8'h00);
    rd(2'd0, d); chk("stop_ctrl", d, 8'h80);
    repeat (5) @(negedge clk);
    chk("stop_hold_pin", 8'(pin), 8'(exp_pin));
    rd(2'd3, d); chk("stop_hold_count", d, 8'h00);

    // 6: asynchronous reset mid-count
    wr(2'd3, 8'h01);
    wr(2'd1, 8'd0);
    wr(2'd2, 8'd100);
    wr(2'd0, 8'h03);
    bus.rd_en = 1'b1;
    bus.addr  = 2'd3;
    repeat (7) @(negedge clk);
    chk("mid_rdata", bus.rdata, 8'd6);
    chk("mid_pin", 8'(pin), 8'h01);
    bus.rd_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_pin", 8'(pin), 8'h00);
    chk("arst_rdata", bus.rdata, 8'h00);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_pin", 8'(pin), 8'h00);
    rd(2'd3, d); chk("idle_count", d, 8'h00);
    rd(2'd0, d); chk("idle_ctrl", d, 8'h00);
    rd(2'd1, d); chk("idle_presc", d, 8'h00);
    rd(2'd2, d); chk("idle_cmp", d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
